pipeline_hazard_controller: RTL and testbench

//  Sequences the ProgramCounter and pipeline registers of the 5-stage datapath. Each cycle it

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/hazard_detect.sv | 34 +++
 rtl/pipeline_hazard_controller.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the 5-stage pipeline hazard controller: PC source
// selects, controller state enum and the hard-wired zero register.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_HALTED  = 2'd2
    } state_e;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection: load-use against EX, plus branch operands
// produced by an ALU op in EX or a load still in MEM.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       id_is_branch_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_rd_i,
    input  logic       mem_mem_read_i,
    input  logic [4:0] mem_rd_i,
    output logic       hazard_o
);

    // Register 0 is hard-wired, so a write to it can never be a dependency.
    function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

    logic ex_match;
    logic mem_match;

    assign ex_match  = src_match(ex_rd_i,  id_rs_i, id_rt_i, id_uses_rt_i);
    assign mem_match = src_match(mem_rd_i, id_rs_i, id_rt_i, id_uses_rt_i);

    assign hazard_o = (ex_mem_read_i && ex_match)
                    | (id_is_branch_i && ((ex_reg_write_i && ex_match)
                                        | (mem_mem_read_i && mem_match)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: stalls on hazards, steers PC redirects, freezes the front
// end for multi-cycle mul/div and external halt, and counts stall cycles.
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_IsBranch,
    input  logic             ID_BranchTaken,
    input  logic             ID_IsJump,
    input  logic             ID_IsMulDiv,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_Rd,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_Rd,
    input  logic             Halt,
    output logic             PCoff,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Bubble,
    output logic [1:0]       PCSrc,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int MD_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

    state_e            state_q, state_d;
    logic [MD_W-1:0]   md_cnt_q, md_cnt_d;
    logic              halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              stall_count_en;
    logic              hazard;

    hazard_detect u_hazard_detect (
        .id_rs_i        (ID_Rs),
        .id_rt_i        (ID_Rt),
        .id_uses_rt_i   (ID_UsesRt),
        .id_is_branch_i (ID_IsBranch),
        .ex_mem_read_i  (EX_MemRead),
        .ex_reg_write_i (EX_RegWrite),
        .ex_rd_i        (EX_Rd),
        .mem_mem_read_i (MEM_MemRead),
        .mem_rd_i       (MEM_Rd),
        .hazard_o       (hazard)
    );

    assign stall_cnt_d = (stall_count_en && (stall_cnt_q != {CNT_W{1'b1}}))
                       ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    assign StallCycles = stall_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_RUN;
            md_cnt_q    <= '0;
            halt_pend_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            halt_pend_q <= halt_pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first so no path infers a latch.
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        halt_pend_d    = halt_pend_q;
        stall_count_en = 1'b0;
        PCoff          = 1'b0;
        IFID_Write     = 1'b1;
        IFID_Flush     = 1'b0;
        IDEX_Write     = 1'b1;
        IDEX_Bubble    = 1'b0;
        EXMEM_Bubble   = 1'b0;
        PCSrc          = PCSRC_SEQ;

        case (state_q)
            ST_RUN: begin
                if (Halt) begin
                    PCoff       = 1'b1;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                    state_d     = ST_HALTED;
                end else if (hazard) begin
                    // Branch stays in ID and re-evaluates next cycle, so no flush.
                    PCoff          = 1'b1;
                    IFID_Write     = 1'b0;
                    IDEX_Bubble    = 1'b1;
                    stall_count_en = 1'b1;
                end else if (ID_IsBranch && ID_BranchTaken) begin
                    PCSrc      = PCSRC_BRANCH;
                    IFID_Flush = 1'b1;
                end else if (ID_IsJump) begin
                    PCSrc      = PCSRC_JUMP;
                    IFID_Flush = 1'b1;
                end else if (ID_IsMulDiv && (MD_LATENCY > 1)) begin
                    md_cnt_d = MD_W'(MD_LATENCY - 1);
                    state_d  = ST_MD_WAIT;
                end
            end
            ST_MD_WAIT: begin
                PCoff          = 1'b1;
                IFID_Write     = 1'b0;
                IDEX_Write     = 1'b0;
                EXMEM_Bubble   = 1'b1;
                stall_count_en = 1'b1;
                if (md_cnt_q == MD_W'(1)) begin
                    state_d     = (halt_pend_q || Halt) ? ST_HALTED : ST_RUN;
                    halt_pend_d = 1'b0;
                end else begin
                    md_cnt_d    = md_cnt_q - MD_W'(1);
                    halt_pend_d = halt_pend_q || Halt;
                end
            end
            ST_HALTED: begin
                PCoff       = 1'b1;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
                if (!Halt) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // Reset forces the safe control pattern immediately, independent of state.
        if (!Reset) begin
            PCoff          = 1'b1;
            IFID_Write     = 1'b0;
            IFID_Flush     = 1'b1;
            IDEX_Write     = 1'b1;
            IDEX_Bubble    = 1'b1;
            EXMEM_Bubble   = 1'b0;
            PCSrc          = PCSRC_SEQ;
            stall_count_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// rule-level reference model; a 2-bit-counter instance exercises saturation.
module tb_pipeline_hazard_controller;

    localparam int MD_LAT = 4;
    localparam int M_RUN = 0, M_MD = 1, M_HALT = 2;

    logic       Clk, Reset;
    logic [4:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
    logic       ID_UsesRt, ID_IsBranch, ID_BranchTaken, ID_IsJump, ID_IsMulDiv;
    logic       EX_MemRead, EX_RegWrite, MEM_MemRead, Halt;

    logic        PCoff, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble;
    logic [1:0]  PCSrc;
    logic [31:0] StallCycles;
    logic        PCoff_s, IFID_Write_s, IFID_Flush_s, IDEX_Write_s, IDEX_Bubble_s, EXMEM_Bubble_s;
    logic [1:0]  PCSrc_s;
    logic [1:0]  StallCycles_s;

    logic [7:0] obs_vec, obs_vec_s;
    assign obs_vec   = {PCoff, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, PCSrc};
    assign obs_vec_s = {PCoff_s, IFID_Write_s, IFID_Flush_s, IDEX_Write_s, IDEX_Bubble_s,
                        EXMEM_Bubble_s, PCSrc_s};

    pipeline_hazard_controller #(.MD_LATENCY(MD_LAT), .CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken), .ID_IsJump(ID_IsJump),
        .ID_IsMulDiv(ID_IsMulDiv), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
        .EX_Rd(EX_Rd), .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd), .Halt(Halt),
        .PCoff(PCoff), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble),
        .PCSrc(PCSrc), .StallCycles(StallCycles)
    );

    pipeline_hazard_controller #(.MD_LATENCY(MD_LAT), .CNT_W(2)) dut_small (
        .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken), .ID_IsJump(ID_IsJump),
        .ID_IsMulDiv(ID_IsMulDiv), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
        .EX_Rd(EX_Rd), .MEM_MemRead(MEM_MemRead), .MEM_Rd(MEM_Rd), .Halt(Halt),
        .PCoff(PCoff_s), .IFID_Write(IFID_Write_s), .IFID_Flush(IFID_Flush_s),
        .IDEX_Write(IDEX_Write_s), .IDEX_Bubble(IDEX_Bubble_s), .EXMEM_Bubble(EXMEM_Bubble_s),
        .PCSrc(PCSrc_s), .StallCycles(StallCycles_s)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model: mode, remaining MD cycles, halt request remembered, raw stall total.
    int          m_mode = M_RUN, m_left = 0;
    bit          m_pend = 1'b0;
    logic [63:0] m_cnt  = '0;
    int          n_mode, n_left;
    bit          n_pend, e_count;
    logic [7:0]  e_vec;
    logic [31:0] exp_cnt;
    logic [1:0]  exp_cnt_s;

    function automatic bit reads(input logic [4:0] r, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic uses_rt);
        return (r != 0) && (r == rs || (uses_rt && r == rt));
    endfunction

    always_comb begin
        bit hz, redirect;
        hz = (EX_MemRead && reads(EX_Rd, ID_Rs, ID_Rt, ID_UsesRt))
          || (ID_IsBranch && EX_RegWrite && reads(EX_Rd, ID_Rs, ID_Rt, ID_UsesRt))
          || (ID_IsBranch && MEM_MemRead && reads(MEM_Rd, ID_Rs, ID_Rt, ID_UsesRt));
        redirect = (ID_IsBranch && ID_BranchTaken) || ID_IsJump;
        n_mode = m_mode; n_left = m_left; n_pend = m_pend; e_count = 1'b0;
        e_vec = 8'b0;
        if (!Reset) begin
            e_vec = 8'b1011_1000;
        end else if (m_mode == M_HALT || (m_mode == M_RUN && Halt)) begin
            e_vec  = 8'b1001_1000;
            n_mode = Halt ? M_HALT : M_RUN;
        end else if (m_mode == M_MD) begin
            e_vec   = 8'b1000_0100;
            e_count = 1'b1;
            if (m_left == 1) begin
                n_mode = (m_pend || Halt) ? M_HALT : M_RUN;
                n_pend = 1'b0;
            end else begin
                n_left = m_left - 1;
                n_pend = m_pend || Halt;
            end
        end else if (hz) begin
            e_vec   = 8'b1001_1000;
            e_count = 1'b1;
        end else begin
            e_vec = {1'b0, 1'b1, redirect, 1'b1, 1'b0, 1'b0,
                     (ID_IsBranch && ID_BranchTaken) ? 2'b01 : (ID_IsJump ? 2'b10 : 2'b00)};
            if (!redirect && ID_IsMulDiv && MD_LAT > 1) begin
                n_mode = M_MD;
                n_left = MD_LAT - 1;
            end
        end
        exp_cnt   = (m_cnt > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : m_cnt[31:0];
        exp_cnt_s = (m_cnt > 64'd3) ? 2'd3 : m_cnt[1:0];
    end

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_mode <= M_RUN; m_left <= 0; m_pend <= 1'b0; m_cnt <= '0;
        end else begin
            m_mode <= n_mode; m_left <= n_left; m_pend <= n_pend;
            if (e_count) m_cnt <= m_cnt + 64'd1;
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_IsBranch = 1'b0;
        ID_BranchTaken = 1'b0; ID_IsJump = 1'b0; ID_IsMulDiv = 1'b0;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_Rd = 5'd0;
        MEM_MemRead = 1'b0; MEM_Rd = 5'd0; Halt = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        #2 Reset = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (obs_vec !== 8'b1011_1000 || StallCycles !== 32'd0 || obs_vec_s !== 8'b1011_1000) begin
            n_err++;
            $display("FAIL reset: ctl=%b cnt=%0d small_ctl=%b, expected ctl=10111000 cnt=0",
                     obs_vec, StallCycles, obs_vec_s);
        end
        next_cycle();
        Reset = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (obs_vec !== e_vec || obs_vec !== 8'b0101_0000) begin
            n_err++;
            $display("FAIL reset_release: ctl=%b, expected ctl=01010000", obs_vec);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        c0 = StallCycles;
        for (int i = 0; i < 2; i++) begin
            idle();
            ID_Rs = 5'd5; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
            if (i == 0) begin EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd5; end
            else begin MEM_MemRead = 1'b1; MEM_Rd = 5'd5; end
            @(negedge Clk);
            n_cmp++;
            if (obs_vec !== e_vec || StallCycles !== exp_cnt || obs_vec_s !== e_vec
                || StallCycles_s !== exp_cnt_s) begin
                n_err++;
                $display("FAIL load_use cyc%0d: ctl=%b cnt=%0d small=%0d, expected ctl=%b cnt=%0d small=%0d",
                         i, obs_vec, StallCycles, StallCycles_s, e_vec, exp_cnt, exp_cnt_s);
            end
            n_cmp++;
            if (PCoff !== (i == 0) || IDEX_Bubble !== (i == 0)) begin
                n_err++;
                $display("FAIL load_use_stall cyc%0d: PCoff=%b IDEX_Bubble=%b, expected %0d",
                         i, PCoff, IDEX_Bubble, i == 0);
            end
            next_cycle();
        end
        @(negedge Clk);
        n_cmp++;
        if (StallCycles - c0 !== 32'd1) begin
            n_err++;
            $display("FAIL load_use_count: delta=%0d, expected 1", StallCycles - c0);
        end
        next_cycle();
    endtask

    task automatic test_branch_load();
        logic [31:0] c0;
        int flushes;
        c0 = StallCycles; flushes = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i < 3) begin ID_IsBranch = 1'b1; ID_BranchTaken = 1'b1; ID_Rs = 5'd5; ID_Rt = 5'd2; ID_UsesRt = 1'b1; end
            if (i == 0) begin EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 5'd5; end
            if (i == 1) begin MEM_MemRead = 1'b1; MEM_Rd = 5'd5; end
            @(negedge Clk);
            n_cmp++;
            if (obs_vec !== e_vec || StallCycles !== exp_cnt || obs_vec_s !== e_vec
                || StallCycles_s !== exp_cnt_s) begin
                n_err++;
                $display("FAIL branch_load cyc%0d: ctl=%b cnt=%0d small=%0d, expected ctl=%b cnt=%0d small=%0d",
                         i, obs_vec, StallCycles, StallCycles_s, e_vec, exp_cnt, exp_cnt_s);
            end
            if (IFID_Flush === 1'b1) flushes++;
            if (i == 2) begin
                n_cmp++;
                if (PCSrc !== 2'b01 || IFID_Flush !== 1'b1) begin
                    n_err++;
                    $display("FAIL branch_redirect: PCSrc=%b flush=%b, expected 01/1", PCSrc, IFID_Flush);
                end
            end
            next_cycle();
        end
        n_cmp++;
        if (StallCycles - c0 !== 32'd2 || flushes != 1) begin
            n_err++;
            $display("FAIL branch_load_totals: stalls=%0d flushes=%0d, expected 2/1",
                     StallCycles - c0, flushes);
        end
    endtask

    task automatic test_reg_zero();
        for (int i = 0; i < 2; i++) begin
            idle();
            EX_MemRead = 1'b1; EX_RegWrite = 1'b1;
            if (i == 0) begin EX_Rd = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b1; end
            else begin EX_Rd = 5'd6; ID_Rs = 5'd3; ID_Rt = 5'd6; ID_UsesRt = 1'b0; end
            @(negedge Clk);
            n_cmp++;
            if (obs_vec !== e_vec || PCoff !== 1'b0 || StallCycles !== exp_cnt) begin
                n_err++;
                $display("FAIL reg_zero cyc%0d: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         i, obs_vec, StallCycles, e_vec, exp_cnt);
            end
            next_cycle();
        end
    endtask

    // halt_at: MD cycle index (1..3) in which Halt pulses, 0 for none; runs issue + 3 MD + tail.
    task automatic test_muldiv(input int halt_at, input int tail, input string tag);
        logic [31:0] c0;
        c0 = StallCycles;
        for (int i = 0; i < 4 + tail; i++) begin
            idle();
            if (i == 0) ID_IsMulDiv = 1'b1;
            if (i == halt_at && halt_at != 0) Halt = 1'b1;
            if (halt_at != 0 && (i == 4 || i == 5)) Halt = 1'b1;
            @(negedge Clk);
            n_cmp++;
            if (obs_vec !== e_vec || StallCycles !== exp_cnt || obs_vec_s !== e_vec
                || StallCycles_s !== exp_cnt_s) begin
                n_err++;
                $display("FAIL %s cyc%0d: ctl=%b cnt=%0d small=%0d, expected ctl=%b cnt=%0d small=%0d",
                         tag, i, obs_vec, StallCycles, StallCycles_s, e_vec, exp_cnt, exp_cnt_s);
            end
            if (i >= 1 && i <= 3) begin
                n_cmp++;
                if (PCoff !== 1'b1 || IDEX_Write !== 1'b0 || EXMEM_Bubble !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s_wait cyc%0d: PCoff=%b IDEX_Write=%b EXMEM_Bubble=%b, expected 1/0/1",
                             tag, i, PCoff, IDEX_Write, EXMEM_Bubble);
                end
            end
            next_cycle();
        end
        @(negedge Clk);
        n_cmp++;
        if (StallCycles - c0 !== 32'd3 || PCoff !== 1'b0) begin
            n_err++;
            $display("FAIL %s_count: delta=%0d PCoff=%b, expected 3/0", tag, StallCycles - c0, PCoff);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_md();
        idle();
        ID_IsMulDiv = 1'b1;
        next_cycle();
        idle();
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec !== 8'b1011_1000 || StallCycles !== 32'd0 || StallCycles_s !== 2'd0) begin
            n_err++;
            $display("FAIL reset_mid_md: ctl=%b cnt=%0d small=%0d, expected ctl=10111000 cnt=0",
                     obs_vec, StallCycles, StallCycles_s);
        end
        next_cycle();
        Reset = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (obs_vec !== e_vec || obs_vec !== 8'b0101_0000 || StallCycles !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_md_run: ctl=%b cnt=%0d, expected ctl=01010000 cnt=0",
                     obs_vec, StallCycles);
        end
        next_cycle();
    endtask

    task automatic test_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            ID_Rs = 5'($urandom_range(0, 3));       ID_Rt = 5'($urandom_range(0, 3));
            EX_Rd = 5'($urandom_range(0, 3));       MEM_Rd = 5'($urandom_range(0, 3));
            ID_UsesRt = 1'($urandom_range(0, 1));
            ID_IsBranch = ($urandom_range(0, 3) == 0);
            ID_BranchTaken = 1'($urandom_range(0, 1));
            ID_IsJump = ($urandom_range(0, 7) == 0);
            ID_IsMulDiv = ($urandom_range(0, 7) == 0);
            EX_MemRead = ($urandom_range(0, 2) == 0);
            EX_RegWrite = 1'($urandom_range(0, 1));
            MEM_MemRead = ($urandom_range(0, 2) == 0);
            Halt = ($urandom_range(0, 15) == 0);
            @(negedge Clk);
            n_cmp++;
            if (obs_vec !== e_vec || StallCycles !== exp_cnt || obs_vec_s !== e_vec
                || StallCycles_s !== exp_cnt_s) begin
                n_err++;
                $display("FAIL random cyc%0d: ctl=%b cnt=%0d small=%0d, expected ctl=%b cnt=%0d small=%0d",
                         i, obs_vec, StallCycles, StallCycles_s, e_vec, exp_cnt, exp_cnt_s);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_reg_zero();
        test_muldiv(0, 1, "muldiv");
        test_muldiv(1, 4, "halt_in_md");
        test_reset_mid_md();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
